// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t : sequencer states (HOLD after reset, RUN, MEM_WAIT on a data-memory wait)
//   fwd_t   : EX operand source select (register file, MEM result, WB result)
//   REG_AW  : architectural register index width
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX source operand.
//   ex_rs                  : source register read by the EX instruction
//   mem_rd / mem_reg_write : destination and write-enable of the MEM instruction
//   wb_rd  / wb_reg_write  : destination and write-enable of the WB instruction
//   sel                    : FWD_MEM, FWD_WB or FWD_RF
// The younger MEM result wins over WB. Register x0 is hard-wired to zero, so it
// is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output fwd_t              sel
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline.
//   clk, rst                        : clock and synchronous active-high reset
//   id_rs1/2, id_use_rs1/2          : sources of the ID instruction and whether they are read
//   ex_rs1/2, ex_rd, ex_mem_read    : EX instruction sources, destination, load flag
//   ex_redirect                     : taken branch / jump resolved in EX
//   mem_rd, mem_reg_write           : MEM destination and write-enable
//   wb_rd, wb_reg_write             : WB destination and write-enable
//   mem_req, mem_ready              : data-memory access in MEM and its completion
//   pc_en, *_en                     : stage register enables
//   if_id_flush, id_ex_flush        : bubble insertion into IF/ID and ID/EX
//   fwd_a, fwd_b                    : EX operand selects (0 RF, 1 MEM, 2 WB)
//   cnt_cycle, cnt_stall, cnt_flush : free-running wrapping performance counters
// After reset the PC is frozen and the pipe flushed for RESET_HOLD cycles. In RUN
// a memory wait has top priority (whole pipe frozen), then an EX redirect (flush
// IF/ID and ID/EX), then a load-use hazard (one-cycle stall with ID/EX bubble).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam int HOLD_W = 4;  // RESET_HOLD is limited to 1..15

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              in_hold;
  logic              load_use;
  logic              mem_stall;
  logic              stall_inc;
  logic              flush_inc;
  fwd_t              sel_a, sel_b;

  // Load-use: the EX load writes a register the ID instruction reads; the value
  // is only available after MEM, so ID must wait one cycle.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // While waiting, the access is already known to be outstanding, so only
  // mem_ready matters; in RUN a fresh request must also be present.
  assign mem_stall = (state == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  // Reset and any non-operating encoding both force the frozen/flushed outputs.
  assign in_hold = rst || ((state != ST_RUN) && (state != ST_MEM_WAIT));

  // State register. Reset is synchronous: it is only sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:     if (hold_cnt == '0) state_nxt = ST_RUN;
      ST_RUN:      if (mem_req && !mem_ready) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_ready) state_nxt = ST_RUN;
      default:     state_nxt = ST_HOLD;
    endcase
  end

  // Output logic: enables, flushes and counter increment strobes.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (in_hold) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      stall_inc = (state == ST_MEM_WAIT);
    end else begin
      // Every MEM_WAIT cycle is a stall cycle, including the completing one; a
      // load-use in that same cycle does not count a second time.
      stall_inc = (state == ST_MEM_WAIT);
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end
    end
  end

  // Hold counter: loaded on reset, counts down to 0 while in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= HOLD_W'(RESET_HOLD - 1);
    end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cycle <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      cnt_cycle <= cnt_cycle + CNT_W'(1);
      cnt_stall <= cnt_stall + CNT_W'(stall_inc);
      cnt_flush <= cnt_flush + CNT_W'(flush_inc);
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );

  // Forwarding is suppressed while the pipe is being flushed after reset.
  assign fwd_a = in_hold ? FWD_RF : sel_a;
  assign fwd_b = in_hold ? FWD_RF : sel_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RESET_HOLD = 2;
  localparam int CNT_W      = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic       mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] cnt_cycle, cnt_stall, cnt_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: frozen cycles still to run, whether a memory access is
  // outstanding, and the three counters.
  int               m_hold_left = 0;
  bit               m_waiting   = 0;
  logic [CNT_W-1:0] m_cyc = '0, m_stall = '0, m_flush = '0;
  bit               chk_en = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it.
  task automatic cycle();
    bit frozen, lu, mstall;
    logic [4:0] e_en;
    logic [1:0] e_fl, e_fa, e_fb;
    @(negedge clk);
    frozen = rst || (m_hold_left > 0);
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mstall = m_waiting ? !mem_ready : (mem_req && !mem_ready);
    e_fa = frozen ? 2'd0 : m_fwd(ex_rs1);
    e_fb = frozen ? 2'd0 : m_fwd(ex_rs2);
    if (frozen)           begin e_en = 5'b01111; e_fl = 2'b11; end
    else if (mstall)      begin e_en = 5'b00000; e_fl = 2'b00; end
    else if (ex_redirect) begin e_en = 5'b11111; e_fl = 2'b11; end
    else if (lu)          begin e_en = 5'b00111; e_fl = 2'b01; end
    else                  begin e_en = 5'b11111; e_fl = 2'b00; end
    if (chk_en) begin
      check("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e_en});
      check("flushes", {30'd0, if_id_flush, id_ex_flush}, {30'd0, e_fl});
      check("fwd_a", {30'd0, fwd_a}, {30'd0, e_fa});
      check("fwd_b", {30'd0, fwd_b}, {30'd0, e_fb});
      check("cnt_cycle", cnt_cycle, m_cyc);
      check("cnt_stall", cnt_stall, m_stall);
      check("cnt_flush", cnt_flush, m_flush);
    end
    @(posedge clk);
    if (rst) begin
      m_hold_left = RESET_HOLD;
      m_waiting   = 0;
      m_cyc = '0; m_stall = '0; m_flush = '0;
    end else begin
      m_cyc++;
      if (m_hold_left > 0) begin
        m_hold_left--;
      end else begin
        bit stall_cycle;
        stall_cycle = m_waiting;
        if (mstall) begin
          m_waiting = 1;
        end else begin
          m_waiting = 0;
          if (ex_redirect) m_flush++;
          else if (lu) stall_cycle = 1;
        end
        if (stall_cycle) m_stall++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_req = 0; mem_ready = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    m_hold_left = RESET_HOLD; m_waiting = 0;
    m_cyc = '0; m_stall = '0; m_flush = '0;
    chk_en = 1;
    cycle();

    // Reset release: PC frozen for RESET_HOLD cycles, then running.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rel_pc_en", {31'd0, pc_en}, (i < RESET_HOLD) ? 32'd0 : 32'd1);
      check("rel_if_id_flush", {31'd0, if_id_flush}, (i < RESET_HOLD) ? 32'd1 : 32'd0);
      cycle();
    end
    check("rel_cnt_cycle", cnt_cycle, 32'd3);

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID.
    ex_mem_read = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; id_use_rs2 = 1; id_rs2 = 7;
    #2;
    check("lu_enables", {29'd0, pc_en, if_id_en, id_ex_flush}, 32'b001);
    cycle();
    check("lu_cnt_stall", cnt_stall, 32'd1);
    // Load now in MEM, add in EX: no stall, MEM forwarding.
    ex_mem_read = 0; ex_rd = 6; ex_rs1 = 5; ex_rs2 = 7;
    mem_rd = 5; mem_reg_write = 1; id_use_rs1 = 0; id_use_rs2 = 0;
    #2;
    check("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    check("lu_after_fwd_a", {30'd0, fwd_a}, 32'd1);
    cycle();

    // Redirect together with load-use: flushes win.
    idle_inputs();
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 9; id_use_rs2 = 1; id_rs2 = 9;
    #2;
    check("redir_flush", {29'd0, pc_en, if_id_flush, id_ex_flush}, 32'b111);
    cycle();
    check("redir_cnt_flush", cnt_flush, 32'd1);
    check("redir_cnt_stall", cnt_stall, 32'd1);

    // Memory wait: three cycles frozen, then completion.
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("wait_enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'd0);
      cycle();
    end
    mem_ready = 1;
    #2;
    check("wait_done_enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'b11111);
    cycle();
    check("wait_cnt_stall", cnt_stall, 32'd1 + 32'd3);
    mem_req = 0;
    #2;
    check("wait_run_pc_en", {31'd0, pc_en}, 32'd1);
    cycle();

    // Forwarding priority and x0.
    ex_rs1 = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
    #2;
    check("fwd_mem_prio", {30'd0, fwd_a}, 32'd1);
    cycle();
    mem_reg_write = 0;
    #2;
    check("fwd_wb", {30'd0, fwd_a}, 32'd2);
    cycle();
    ex_rs2 = 0; wb_rd = 0;
    #2;
    check("fwd_x0", {30'd0, fwd_b}, 32'd0);
    cycle();

    // Reset asserted during MEM_WAIT.
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    cycle();
    cycle();
    rst = 1;
    #2;
    check("rst_wait_pc_en", {31'd0, pc_en}, 32'd0);
    cycle();
    rst = 0;
    #2;
    check("rst_cnt_cycle", cnt_cycle, 32'd0);
    check("rst_cnt_stall", cnt_stall, 32'd0);
    check("rst_cnt_flush", cnt_flush, 32'd0);
    check("rst_hold_pc_en", {31'd0, pc_en}, 32'd0);
    cycle();
    cycle();
    cycle();

    // Random phase: small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_rs1        = 5'($urandom_range(0, 3));
      ex_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_mem_read   = ($urandom_range(0, 99) < 40);
      ex_redirect   = ($urandom_range(0, 99) < 15);
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      mem_req       = ($urandom_range(0, 99) < 35);
      mem_ready     = ($urandom_range(0, 99) < 60);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
